// File: rtl/rtype_seq_ctrl.sv
// rtype_seq_ctrl: multi-cycle sequencer for the R-type execute datapath.
// Takes one instruction word per valid/ready transfer, then walks it through
// DECODE -> EXEC -> WB. Drives register addresses, ALU control and a
// single-cycle register write enable.
//
// Ports:
//   CLK, RST      clock (rising edge), synchronous active-high reset
//   instr_valid   instruction word on instr is valid
//   instr[31:0]   MIPS instruction word
//   instr_ready   high only in IDLE
//   ra/rb/rw      register addresses, always taken from the latched IR
//   alu_ctrl      ALU operation select, registered in DECODE
//   reg_we        register write enable, one cycle in WB
//   done          one-cycle pulse when an instruction retires
//   illegal       one-cycle pulse in DECODE when an instruction is rejected
//   state_o       IDLE=0, DECODE=1, EXEC=2, WB=3
//   retire_cnt    (only with RETIRE_CNT_EN) count of retired instructions
//
// Optional feature macro: RETIRE_CNT_EN
module rtype_seq_ctrl #(
  parameter int CNT_W            = 16,
  parameter int ZERO_REG_PROTECT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [4:0]       ra,
  output logic [4:0]       rb,
  output logic [4:0]       rw,
  output logic [2:0]       alu_ctrl,
  output logic             reg_we,
  output logic             done,
  output logic             illegal,
  output logic [1:0]       state_o
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] ir;
  logic [2:0]  dec_alu;
  logic        funct_ok;
  logic        legal;

  assign ra      = ir[25:21];
  assign rb      = ir[20:16];
  assign rw      = ir[15:11];
  assign state_o = state;

  // funct -> ALU op; anything not listed is rejected
  always_comb begin
    dec_alu  = 3'b010;
    funct_ok = 1'b1;
    case (ir[5:0])
      6'b100000, 6'b100001: dec_alu = 3'b010;
      6'b100010, 6'b100011: dec_alu = 3'b110;
      6'b100100:            dec_alu = 3'b000;
      6'b100101:            dec_alu = 3'b001;
      6'b101010:            dec_alu = 3'b111;
      default:              funct_ok = 1'b0;
    endcase
  end

  // Non-zero shamt is rejected: only shift-free R-type ops are supported
  assign legal = (ir[31:26] == 6'd0) && (ir[10:6] == 5'd0) && funct_ok;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    instr_ready = 1'b0;
    reg_we      = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_n = DECODE;
      end
      DECODE: begin
        if (legal) state_n = EXEC;
        else begin
          illegal = 1'b1;
          state_n = IDLE;
        end
      end
      EXEC: state_n = WB;
      WB: begin
        // writes to r0 are dropped but the instruction still retires
        reg_we  = !((ZERO_REG_PROTECT != 0) && (rw == 5'd0));
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // IR only changes on an accepted transfer, so ra/rb/rw hold through WB
  always_ff @(posedge CLK) begin
    if (RST)                               ir <= 32'd0;
    else if (state == IDLE && instr_valid) ir <= instr;
  end

  always_ff @(posedge CLK) begin
    if (RST)                           alu_ctrl <= 3'b010;
    else if (state == DECODE && legal) alu_ctrl <= dec_alu;
  end

`ifdef RETIRE_CNT_EN
  // wraps naturally at all-ones
  always_ff @(posedge CLK) begin
    if (RST)       retire_cnt <= '0;
    else if (done) retire_cnt <= retire_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_rtype_seq_ctrl.sv
// Bench for rtype_seq_ctrl: table of instruction words with expected ALU op,
// legality and write enable, plus hand sequences for back-to-back accepts and
// reset mid-instruction. Expected retirements are queued on accept and
// popped when done/illegal pulses.
module tb_rtype_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  ra, rb, rw;
  logic [2:0]  alu_ctrl;
  logic        reg_we, done, illegal;
  logic [1:0]  state_o;
`ifdef RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  rtype_seq_ctrl dut (
    .CLK(CLK), .RST(RST), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ra(ra), .rb(rb), .rw(rw),
    .alu_ctrl(alu_ctrl), .reg_we(reg_we), .done(done), .illegal(illegal),
    .state_o(state_o)
`ifdef RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] word;
    logic [2:0]  alu;
    logic        legal;
    logic        we;
  } vec_t;

  typedef struct {
    logic [4:0] ra, rb, rw;
    logic [2:0] alu;
    logic       legal;
    logic       we;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   exp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic exp_t mk(input vec_t v, input int acc);
    exp_t e;
    e.ra = v.word[25:21]; e.rb = v.word[20:16]; e.rw = v.word[15:11];
    e.alu = v.alu; e.legal = v.legal; e.we = v.we; e.acc = acc;
    return e;
  endfunction

  // Advance one clock and sample 1ns after the edge; retirement monitor.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    cyc++;
    if (done && illegal) chk("done_and_illegal", 1, 0);
    if (reg_we && !done) chk("we_without_done", 1, 0);
    if (done || illegal) begin
      if (q.size() == 0) chk("unexpected_retire", {done, illegal}, 0);
      else begin
        e = q.pop_front();
        chk("retire_kind", done, e.legal);
        chk("retire_latency", cyc - e.acc, e.legal ? 3 : 1);
        if (done) begin
          chk("reg_we", reg_we, e.we);
          chk("alu_ctrl_wb", alu_ctrl, e.alu);
          chk("rw_wb", rw, e.rw);
          exp_cnt++;
        end
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin tick(); n++; end
    if (!instr_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic run_instr(input vec_t v);
    exp_t e;
    instr = v.word; instr_valid = 1'b1;
    wait_ready();
    e = mk(v, cyc);
    q.push_back(e);
    tick();
    instr_valid = 1'b0;
    instr = $urandom;   // must be ignored outside IDLE
    chk("state_decode", state_o, 1);
    chk("ready_busy", instr_ready, 0);
    chk("ra", ra, e.ra); chk("rb", rb, e.rb); chk("rw", rw, e.rw);
    if (v.legal) begin
      tick(); chk("state_exec", state_o, 2); chk("alu_exec", alu_ctrl, v.alu);
      tick(); chk("state_wb", state_o, 3);
    end
    tick();
    chk("state_idle", state_o, 0);
    chk("ready_idle", instr_ready, 1);
  endtask

  vec_t tbl[11];

  initial begin
    exp_t e;
    int a1;
    logic [31:0] w1, w2;
    vec_t v2;

    tbl[0]  = '{32'h00221820, 3'b010, 1'b1, 1'b1};
    tbl[1]  = '{32'h00221821, 3'b010, 1'b1, 1'b1};
    tbl[2]  = '{32'h00221822, 3'b110, 1'b1, 1'b1};
    tbl[3]  = '{32'h00221823, 3'b110, 1'b1, 1'b1};
    tbl[4]  = '{32'h00221824, 3'b000, 1'b1, 1'b1};
    tbl[5]  = '{32'h8C220004, 3'b000, 1'b0, 1'b0};  // lw
    tbl[6]  = '{32'h00221825, 3'b001, 1'b1, 1'b1};
    tbl[7]  = '{32'h00221860, 3'b000, 1'b0, 1'b0};  // add, shamt=1
    tbl[8]  = '{32'h0022182A, 3'b111, 1'b1, 1'b1};
    tbl[9]  = '{32'h00221826, 3'b000, 1'b0, 1'b0};  // xor: not supported
    tbl[10] = '{32'h00220020, 3'b010, 1'b1, 1'b0};  // rw=0

    RST = 1'b1; instr_valid = 1'b0; instr = 32'hFFFF_FFFF;
    tick(); tick();
    RST = 1'b0;
    chk("rst_state", state_o, 0);
    chk("rst_alu", alu_ctrl, 3'b010);
    chk("rst_ra", ra, 0); chk("rst_rb", rb, 0); chk("rst_rw", rw, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_pulses", {reg_we, done, illegal}, 0);
`ifdef RETIRE_CNT_EN
    chk("rst_cnt", retire_cnt, 0);
`endif

    // idle without valid stays idle
    tick(); tick();
    chk("idle_hold", state_o, 0);

    foreach (tbl[i]) run_instr(tbl[i]);
    chk("queue_drained", q.size(), 0);
`ifdef RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, exp_cnt);
`endif

    // valid held high across two words: accepts 4 cycles apart
    w1 = 32'h00221820; w2 = 32'h00853822;
    v2 = '{w2, 3'b110, 1'b1, 1'b1};
    instr = w1; instr_valid = 1'b1;
    wait_ready();
    a1 = cyc;
    q.push_back(mk(tbl[0], cyc));
    tick();
    instr = w2;
    for (int k = 1; k <= 3; k++) begin
      chk("b2b_ready_busy", instr_ready, 0);
      chk("b2b_ra_hold", ra, w1[25:21]);
      chk("b2b_rw_hold", rw, w1[15:11]);
      tick();
    end
    chk("b2b_state_idle", state_o, 0);
    chk("b2b_ready", instr_ready, 1);
    chk("b2b_spacing", cyc - a1, 4);
    e = mk(v2, cyc);
    q.push_back(e);
    tick();
    instr_valid = 1'b0;
    chk("b2b_ra2", ra, e.ra); chk("b2b_rb2", rb, e.rb); chk("b2b_rw2", rw, e.rw);
    tick(); tick(); tick();
    chk("b2b_end_idle", state_o, 0);
    chk("b2b_drained", q.size(), 0);

    // reset while in EXEC: no WB pulse afterwards
    instr = 32'h00221825; instr_valid = 1'b1;
    wait_ready();
    tick();
    instr_valid = 1'b0;
    tick();
    chk("mid_state_exec", state_o, 2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_cnt = 0;
    chk("mid_rst_state", state_o, 0);
    chk("mid_rst_ra", ra, 0); chk("mid_rst_rb", rb, 0); chk("mid_rst_rw", rw, 0);
    chk("mid_rst_alu", alu_ctrl, 3'b010);
    chk("mid_rst_pulses", {reg_we, done}, 0);
`ifdef RETIRE_CNT_EN
    chk("mid_rst_cnt", retire_cnt, 0);
`endif
    tick(); tick(); tick(); tick();
    chk("post_rst_idle", state_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
